// File: rtl/dff_pkg.sv
// Shared constants and the width helper for the dff_pipeline block.
package dff_pkg;

  localparam int          DFF_WIDTH     = 4;
  localparam int          DFF_DEPTH     = 3;
  localparam logic [63:0] DFF_RESET_VAL = 64'd0;

  // Ceiling log2, never less than 1 so a select/count port always has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One register stage: data plus valid flag, with stall, flush and bubble fill.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DFF_RESET_VAL[WIDTH-1:0]
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_q
);

  // Flush wins over shift; an invalid input loads RESET_VAL so bubbles carry a known value.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid <= 1'b0;
      o_q     <= RESET_VAL;
    end else if (i_clr) begin
      o_valid <= 1'b0;
      o_q     <= RESET_VAL;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_q     <= i_valid ? i_d : RESET_VAL;
    end
  end

endmodule

// File: rtl/dff_pipeline.sv
// Parameterised delay line with valid tracking, fill counter and a tap mux.
module dff_pipeline
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH,
  parameter int               DEPTH     = DFF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DFF_RESET_VAL[WIDTH-1:0],
  localparam int              SEL_W     = clog2(DEPTH),
  localparam int              FILL_W    = clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_d,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_tap,
  output logic              o_tap_valid,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_empty,
  output logic              o_full
);

  localparam int                TAPS     = 1 << SEL_W;
  localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  stage_d [DEPTH];
  logic [DEPTH-1:0]  stage_v;
  logic [WIDTH-1:0]  in_d    [DEPTH];
  logic [DEPTH-1:0]  in_v;
  logic [WIDTH-1:0]  tap_d   [TAPS];
  logic [TAPS-1:0]   tap_v;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_nxt;

  // Stage chain: stage 0 takes the ports, each later stage takes its predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_v[k] = i_valid;
      assign in_d[k] = i_d;
    end else begin : g_body
      assign in_v[k] = stage_v[k-1];
      assign in_d[k] = stage_d[k-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_clr   (i_clr),
      .i_valid (in_v[k]),
      .i_d     (in_d[k]),
      .o_valid (stage_v[k]),
      .o_q     (stage_d[k])
    );
  end

  // One valid in and one valid out cancel, so a full pipe stays at DEPTH.
  assign fill_nxt = fill_q + FILL_W'(i_valid) - FILL_W'(stage_v[DEPTH-1]);

  // Occupancy count tracks the stage valids: cleared with them, held on stall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fill_q <= '0;
    end else if (i_clr) begin
      fill_q <= '0;
    end else if (i_en) begin
      fill_q <= fill_nxt;
    end
  end

  // Tap table padded to a power of two so out-of-range selects read idle values.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    if (t < DEPTH) begin : g_real
      assign tap_d[t] = stage_d[t];
      assign tap_v[t] = stage_v[t];
    end else begin : g_pad
      assign tap_d[t] = RESET_VAL;
      assign tap_v[t] = 1'b0;
    end
  end

  assign o_tap       = tap_d[i_sel];
  assign o_tap_valid = tap_v[i_sel];

  assign o_q     = stage_d[DEPTH-1];
  assign o_valid = stage_v[DEPTH-1];
  assign o_fill  = fill_q;
  assign o_empty = (fill_q == '0);
  assign o_full  = (fill_q == FULL_CNT);

endmodule
